// File: rtl/thread_fetch_pkg.sv
// Shared thread/PC sizing for the fetch, register-file and decode stages.
package thread_fetch_pkg;

    localparam int NTHREADS = 4;
    localparam int TID_W    = 2;
    localparam int PC_W_DEF = 9;

    typedef logic [TID_W-1:0]    tid_t;
    typedef logic [NTHREADS-1:0] tmask_t;

    // One-hot mask for a single thread ID.
    function automatic tmask_t tid_onehot(input tid_t tid);
        return tmask_t'(1) << tid;
    endfunction

endpackage

// File: rtl/thread_fetch_rr.sv
// Rotating-priority pick over four threads, searching from last+1 onward.
module rr_arbiter4
    import thread_fetch_pkg::*;
(
    input  logic [NTHREADS-1:0] eligible,
    input  logic [TID_W-1:0]    last,
    output logic                grant_valid,
    output logic [TID_W-1:0]    grant
);

    logic [TID_W-1:0] cand;

    // With nothing eligible, grant still points at last+1 so the fetch
    // address stays meaningful.
    always_comb begin
        grant_valid = 1'b0;
        grant       = last + TID_W'(1);
        cand        = '0;
        for (int i = 1; i <= NTHREADS; i++) begin
            cand = last + TID_W'(i);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant       = cand;
            end
        end
    end

endmodule

// File: rtl/thread_fetch.sv
// Four-thread round-robin instruction fetch with per-thread PC, redirect and halt.
module thread_fetch
    import thread_fetch_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [NTHREADS-1:0] thread_active,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [TID_W-1:0]    redirect_thread,
    input  logic [PC_W-1:0]     redirect_pc,
    input  logic                halt_valid,
    input  logic [TID_W-1:0]    halt_thread,
    output logic [PC_W-1:0]     imem_addr,
    output logic                fetch_valid,
    output logic [TID_W-1:0]    fetch_thread,
    output logic [PC_W-1:0]     fetch_pc,
    output logic                all_halted
);

    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

    logic [PC_W-1:0]     pc [NTHREADS];
    logic [NTHREADS-1:0] halted;
    logic [TID_W-1:0]    last;

    logic [NTHREADS-1:0] redir_mask;
    logic [NTHREADS-1:0] eligible;
    logic                grant_valid;
    logic [TID_W-1:0]    grant;
    logic                issue;

    // A thread being redirected this cycle must not fetch from its stale PC.
    assign redir_mask = redirect_valid ? tid_onehot(redirect_thread) : '0;
    assign eligible   = thread_active & ~halted & ~redir_mask;

    rr_arbiter4 u_arb (
        .eligible    (eligible),
        .last        (last),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign issue      = ~stall & grant_valid;
    assign imem_addr  = pc[grant];
    assign all_halted = &(halted | ~thread_active);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int t = 0; t < NTHREADS; t++) pc[t] <= RST_PC;
            halted       <= '0;
            last         <= TID_W'(NTHREADS - 1);
            fetch_valid  <= 1'b0;
            fetch_thread <= '0;
            fetch_pc     <= '0;
        end else begin
            fetch_valid <= issue;
            if (issue) begin
                pc[grant]    <= pc[grant] + PC_W'(1);
                last         <= grant;
                fetch_thread <= grant;
                fetch_pc     <= pc[grant];
            end
            // Redirected thread is never the granted one, so no write conflict.
            if (redirect_valid) pc[redirect_thread] <= redirect_pc;
            if (halt_valid)     halted[halt_thread] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_thread_fetch.sv
// Directed-vector bench for thread_fetch with hand-computed expectations.
module tb_thread_fetch;

    logic       clk;
    logic       clr;
    logic [3:0] thread_active;
    logic       stall;
    logic       redirect_valid;
    logic [1:0] redirect_thread;
    logic [8:0] redirect_pc;
    logic       halt_valid;
    logic [1:0] halt_thread;
    logic [8:0] imem_addr;
    logic       fetch_valid;
    logic [1:0] fetch_thread;
    logic [8:0] fetch_pc;
    logic       all_halted;

    int n_cmp = 0;
    int n_err = 0;

    thread_fetch #(.PC_W(9), .RESET_PC(0)) dut (
        .clk             (clk),
        .clr             (clr),
        .thread_active   (thread_active),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_thread (redirect_thread),
        .redirect_pc     (redirect_pc),
        .halt_valid      (halt_valid),
        .halt_thread     (halt_thread),
        .imem_addr       (imem_addr),
        .fetch_valid     (fetch_valid),
        .fetch_thread    (fetch_thread),
        .fetch_pc        (fetch_pc),
        .all_halted      (all_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic [1:0] thr, input logic [8:0] pcv);
        chk({tag, ".valid"}, 32'(fetch_valid), 32'd1);
        chk({tag, ".thread"}, 32'(fetch_thread), 32'(thr));
        chk({tag, ".pc"}, 32'(fetch_pc), 32'(pcv));
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        chk("clr.valid", 32'(fetch_valid), 32'd0);
        clr = 1'b0;
        #1;
    endtask

    initial begin
        clr = 1'b1;
        thread_active = 4'b0000;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_thread = 2'd0;
        redirect_pc = 9'd0;
        halt_valid = 1'b0;
        halt_thread = 2'd0;
        #12;

        // Reset state
        chk("rst.valid", 32'(fetch_valid), 32'd0);
        chk("rst.thread", 32'(fetch_thread), 32'd0);
        chk("rst.pc", 32'(fetch_pc), 32'd0);
        chk("rst.imem", 32'(imem_addr), 32'd0);
        chk("rst.allh_none_active", 32'(all_halted), 32'd1);

        // Full round-robin from reset
        thread_active = 4'b1111;
        #1;
        chk("rr.allh", 32'(all_halted), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("rr.first_cycle_valid", 32'(fetch_valid), 32'd0);
        chk("rr.imem0", 32'(imem_addr), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_fetch($sformatf("rr%0d", i), 2'(i % 4), 9'(i / 4));
        end
        // pcs now 2,2,1,1 ; last=1

        // Stall three cycles, then resume where we left off
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d.valid", i), 32'(fetch_valid), 32'd0);
            chk($sformatf("stall%0d.hold_pc", i), 32'(fetch_pc), 32'd1);
        end
        stall = 1'b0;
        tick(); chk_fetch("resume0", 2'd2, 9'd1);
        tick(); chk_fetch("resume1", 2'd3, 9'd1);
        tick(); chk_fetch("resume2", 2'd0, 9'd2);
        // pcs 3,2,2,2 ; last=0

        // Redirect thread 1 while it is next in line
        redirect_valid = 1'b1;
        redirect_thread = 2'd1;
        redirect_pc = 9'h040;
        #1;
        chk("redir.imem_skip", 32'(imem_addr), 32'd2);
        tick(); chk_fetch("redir.skip", 2'd2, 9'd2);
        redirect_valid = 1'b0;
        tick(); chk_fetch("redir.t3", 2'd3, 9'd2);
        tick(); chk_fetch("redir.t0", 2'd0, 9'd3);
        tick(); chk_fetch("redir.t1", 2'd1, 9'h040);

        // Two active threads alternate; inactive PCs frozen
        do_clr();
        thread_active = 4'b0101;
        #1;
        chk("alt.allh", 32'(all_halted), 32'd0);
        tick(); chk_fetch("alt0", 2'd0, 9'd0);
        tick(); chk_fetch("alt1", 2'd2, 9'd0);
        tick(); chk_fetch("alt2", 2'd0, 9'd1);
        tick(); chk_fetch("alt3", 2'd2, 9'd1);
        thread_active = 4'b1111;
        tick(); chk_fetch("thaw.t3", 2'd3, 9'd0);
        tick(); chk_fetch("thaw.t0", 2'd0, 9'd2);
        tick(); chk_fetch("thaw.t1", 2'd1, 9'd0);
        // pcs 3,1,2,1 ; last=1

        // Halt threads 0..3 one per edge
        halt_valid = 1'b1;
        halt_thread = 2'd0;
        tick(); chk_fetch("halt0", 2'd2, 9'd2);
        chk("halt0.allh", 32'(all_halted), 32'd0);
        halt_thread = 2'd1;
        tick(); chk_fetch("halt1", 2'd3, 9'd1);
        chk("halt1.allh", 32'(all_halted), 32'd0);
        halt_thread = 2'd2;
        tick(); chk_fetch("halt2_same_cycle", 2'd2, 9'd3);
        chk("halt2.allh", 32'(all_halted), 32'd0);
        halt_thread = 2'd3;
        tick(); chk_fetch("halt3_same_cycle", 2'd3, 9'd2);
        chk("halt3.allh", 32'(all_halted), 32'd1);
        halt_valid = 1'b0;
        tick(); chk("halted.valid0", 32'(fetch_valid), 32'd0);
        tick(); chk("halted.valid1", 32'(fetch_valid), 32'd0);

        // clr mid-operation; redirect/halt presented during clr are ignored
        clr = 1'b1;
        redirect_valid = 1'b1;
        redirect_thread = 2'd0;
        redirect_pc = 9'h0AA;
        halt_valid = 1'b1;
        halt_thread = 2'd0;
        tick();
        chk("clr2.valid", 32'(fetch_valid), 32'd0);
        redirect_valid = 1'b0;
        halt_valid = 1'b0;
        clr = 1'b0;
        #1;
        chk("clr2.allh", 32'(all_halted), 32'd0);
        chk("clr2.imem", 32'(imem_addr), 32'd0);
        tick(); chk_fetch("restart0", 2'd0, 9'd0);
        tick(); chk_fetch("restart1", 2'd1, 9'd0);

        // Redirect + halt of the same thread in one cycle
        do_clr();
        thread_active = 4'b0011;
        redirect_valid = 1'b1;
        redirect_thread = 2'd1;
        redirect_pc = 9'h010;
        halt_valid = 1'b1;
        halt_thread = 2'd1;
        tick(); chk_fetch("rh0", 2'd0, 9'd0);
        redirect_valid = 1'b0;
        halt_valid = 1'b0;
        tick(); chk_fetch("rh1", 2'd0, 9'd1);
        chk("rh.allh", 32'(all_halted), 32'd0);
        halt_valid = 1'b1;
        halt_thread = 2'd0;
        tick(); chk_fetch("rh2", 2'd0, 9'd2);
        halt_valid = 1'b0;
        chk("rh.allh_after", 32'(all_halted), 32'd1);

        // PC wrap at 2^PC_W-1
        do_clr();
        thread_active = 4'b0001;
        redirect_valid = 1'b1;
        redirect_thread = 2'd0;
        redirect_pc = 9'h1FF;
        tick(); chk("wrap.redir_noissue", 32'(fetch_valid), 32'd0);
        redirect_valid = 1'b0;
        #1;
        chk("wrap.imem", 32'(imem_addr), 32'h1FF);
        tick(); chk_fetch("wrap0", 2'd0, 9'h1FF);
        tick(); chk_fetch("wrap1", 2'd0, 9'h000);
        tick(); chk_fetch("wrap2", 2'd0, 9'h001);

        // Redirect lands even while stalled
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 9'h123;
        tick(); chk("stredir.valid", 32'(fetch_valid), 32'd0);
        redirect_valid = 1'b0;
        stall = 1'b0;
        tick(); chk_fetch("stredir", 2'd0, 9'h123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
